// File: rtl/planificador_muestras.sv
// planificador_muestras
// Frame scheduler that shares one byte-wide transmit link among NUM_REQ
// sample producers. Each rising edge of samp_rate opens a frame: the set of
// requesters pending at that instant is snapshotted and each one is served
// with a single byte, in round-robin order, over a valid/ready handshake.
// Frames that open while the previous one is still draining are dropped and
// counted in a saturating overrun counter.
//
// Ports
//   clock_in     system clock
//   rst_n        asynchronous active-low reset
//   samp_rate    sample-rate square wave; each rising edge starts a frame
//   req          per-requester "byte available" levels
//   req_data     requester i byte at [i*DATA_W +: DATA_W]
//   ack          one-hot, one-cycle pulse after requester i's byte is accepted
//   tx_data      byte to the host link
//   tx_valid     tx_data valid
//   tx_ready     host link accepts
//   busy         high whenever the scheduler is not idle
//   overrun_cnt  saturating count of dropped frames
module planificador_muestras #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int OVR_W   = 8
) (
  input  logic                      clock_in,
  input  logic                      rst_n,
  input  logic                      samp_rate,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [OVR_W-1:0]          overrun_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SEND
  } state_t;

  state_t               state_q, state_d;
  logic                 samp_q;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [OVR_W-1:0]     ovr_q, ovr_d;

  logic                 frame_start;
  logic [PTR_W-1:0]     pick;
  logic [PTR_W-1:0]     pick_next;

  // samp_q resets to 1 so a samp_rate already high at reset release is not
  // mistaken for a rising edge.
  assign frame_start = samp_rate & ~samp_q;

  // Cyclic first-set search starting at ptr. Walking the offsets from the
  // farthest to the nearest lets the nearest hit overwrite the others, so no
  // early exit is needed.
  always_comb begin
    pick = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (pending_q[idx[PTR_W-1:0]]) pick = idx[PTR_W-1:0];
    end
  end

  assign pick_next = (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + PTR_W'(1);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ack_d      = '0;
    ovr_d      = ovr_q;

    // A frame opening while still busy is discarded; only the count changes.
    if (frame_start && (state_q != ST_IDLE) && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_d = ovr_q + OVR_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          pending_d = req;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (pending_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tx_data_d        = req_data[int'(pick)*DATA_W +: DATA_W];
          tx_valid_d       = 1'b1;
          sel_d            = pick;
          pending_d[pick]  = 1'b0;
          ptr_d            = pick_next;
          state_d          = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          ack_d      = NUM_REQ'(1) << sel_q;
          state_d    = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      samp_q     <= 1'b1;
      pending_q  <= '0;
      ptr_q      <= '0;
      sel_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ack_q      <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_rate;
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ack_q      <= ack_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ack         = ack_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_planificador_muestras.sv
// Bench for planificador_muestras: directed frames with hand-derived byte
// order; a scoreboard queue holds the expected bytes and ack patterns, and a
// monitor on the falling clock edge checks each accepted byte and its ack.
module tb_planificador_muestras;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int OW   = 2;

  logic              clk;
  logic              rst_n;
  logic              samp_rate;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [DW-1:0]     tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic [OW-1:0]     overrun_cnt;

  planificador_muestras #(.NUM_REQ(NREQ), .DATA_W(DW), .OVR_W(OW)) dut (
    .clock_in    (clk),
    .rst_n       (rst_n),
    .samp_rate   (samp_rate),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  typedef struct {
    logic [DW-1:0]   d;
    logic [NREQ-1:0] a;
  } exp_t;

  exp_t sb[$];
  int   ack_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic ack_due = 1'b0;
  logic [NREQ-1:0] ack_exp = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: ack check for the previous accept, then the current handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_due) begin
        chk("ack", 32'(ack), 32'(ack_exp));
        ack_cyc.push_back(cyc);
        ack_due = 1'b0;
      end else if (ack !== '0) begin
        chk("unexpected_ack", 32'(ack), 32'h0);
      end
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.d));
          ack_exp = e.a;
          ack_due = 1'b1;
        end
      end
    end
  end

  task automatic push(input logic [DW-1:0] d, input logic [NREQ-1:0] a);
    exp_t e;
    e.d = d;
    e.a = a;
    sb.push_back(e);
  endtask

  task automatic set_byte(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // Single rising edge of samp_rate; returns 1ns after the edge that sees it.
  task automatic start_frame();
    @(posedge clk); #1 samp_rate = 1'b1;
    @(posedge clk); #1 samp_rate = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({nm, "_idle_timeout"}, 32'(busy), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid_seen"}, 32'(tx_valid), 32'h1);
  endtask

  initial begin
    int n;
    int bad;
    int base;
    rst_n     = 1'b0;
    samp_rate = 1'b0;
    req       = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_ovr", 32'(overrun_cnt), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // All four pending from ptr 0: bytes 10..13, acks two cycles apart.
    tx_ready = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_byte(i, 8'h10 + 8'(i));
    push(8'h10, 4'b0001); push(8'h11, 4'b0010);
    push(8'h12, 4'b0100); push(8'h13, 4'b1000);
    ack_cyc.delete();
    start_frame();
    wait_idle("all");
    chk("all_ack_count", 32'(ack_cyc.size()), 32'd4);
    if (ack_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("all_ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);
    end

    // Single requester with latency checks; ptr ends at 3.
    req = 4'b0100;
    set_byte(2, 8'hA5);
    push(8'hA5, 4'b0100);
    start_frame();
    chk("single_busy_E", 32'(busy), 32'h1);
    chk("single_valid_E", 32'(tx_valid), 32'h0);
    @(posedge clk); #1;
    chk("single_valid_E1", 32'(tx_valid), 32'h1);
    chk("single_data_E1", 32'(tx_data), 32'hA5);
    n = 0;
    @(negedge clk);
    while (ack === '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("single_busy_after_ack", 32'(busy), 32'h1);
    @(negedge clk);
    chk("single_busy_fall", 32'(busy), 32'h0);
    @(posedge clk); #1;

    // Rotation: ptr 3 -> order 0,1 (ptr 2); again 0,1 (ptr 2).
    req = 4'b0011;
    set_byte(0, 8'h20); set_byte(1, 8'h21);
    push(8'h20, 4'b0001); push(8'h21, 4'b0010);
    start_frame(); wait_idle("rot1");
    push(8'h20, 4'b0001); push(8'h21, 4'b0010);
    start_frame(); wait_idle("rot2");
    // req 0001 from ptr 2 -> 0 (ptr 1); then 0011 from ptr 1 -> order 1,0.
    req = 4'b0001;
    push(8'h20, 4'b0001);
    start_frame(); wait_idle("rot3");
    req = 4'b0011;
    push(8'h21, 4'b0010); push(8'h20, 4'b0001);
    start_frame(); wait_idle("rot4");

    // Backpressure: requester 3 from ptr 1, held 20 cycles.
    tx_ready = 1'b0;
    req = 4'b1000;
    set_byte(3, 8'h77);
    push(8'h77, 4'b1000);
    start_frame();
    wait_valid("bp");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h77 || ack !== '0) bad++;
    end
    chk("bp_stable", 32'(bad), 32'h0);
    base = ack_cyc.size();
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle("bp");
    chk("bp_single_ack", 32'(ack_cyc.size() - base), 32'd1);

    // Overrun: 3 drops during SEND; pending set {1,2} unchanged.
    tx_ready = 1'b0;
    req = 4'b0110;
    set_byte(1, 8'hB1); set_byte(2, 8'hB2);
    push(8'hB1, 4'b0010); push(8'hB2, 4'b0100);
    start_frame();
    wait_valid("ovr");
    req = 4'b1111;
    set_byte(0, 8'hEE); set_byte(3, 8'hEE);
    repeat (3) start_frame();
    @(negedge clk);
    chk("ovr_cnt3", 32'(overrun_cnt), 32'd3);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle("ovr");
    chk("ovr_sb_drained", 32'(sb.size()), 32'd0);

    // Saturation: two more drops with a 2-bit counter stay at 3.
    tx_ready = 1'b0;
    req = 4'b0001;
    set_byte(0, 8'hC3);
    push(8'hC3, 4'b0001);
    start_frame();
    wait_valid("sat");
    repeat (2) start_frame();
    @(negedge clk);
    chk("ovr_saturated", 32'(overrun_cnt), 32'd3);

    // Asynchronous reset in the middle of SEND.
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_ovr", 32'(overrun_cnt), 32'h0);
    sb.delete();
    samp_rate = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_valid !== 1'b0) bad++;
    end
    chk("no_frame_after_rst", 32'(bad), 32'h0);
    samp_rate = 1'b0;
    repeat (2) @(posedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
